// File: rtl/calib_frame_tx.sv
// Frames a completed calibration batch from the ping-pong RAM into a checksummed byte stream
// with valid/ready handshake, a 4-byte read prefetch FIFO and a one-deep pending batch slot.
module calib_frame_tx #(
  parameter logic [15:0] SYNC_WORD  = 16'hCA1B,
  parameter logic [7:0]  FRAME_TYPE = 8'h5A,
  parameter int          MAX_POINTS = 128
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_calib_make,
  input  logic        i_calib_pingpang,
  input  logic [15:0] i_calib_points,
  output logic [10:0] o_ram_rdaddr,
  output logic        o_ram_rden,
  input  logic [7:0]  i_ram_rddata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt
);

  localparam logic [15:0] MAX_PTS = 16'(MAX_POINTS);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CSUM, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  seq_reg, seq_next;
  logic        bank_reg, bank_next;
  logic [15:0] points_reg, points_next;
  logic [18:0] len_reg, len_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        pend_bank_reg, pend_bank_next;
  logic [15:0] pend_points_reg, pend_points_next;
  logic [7:0]  drop_reg, drop_next;
  logic [2:0]  hdr_idx_reg, hdr_idx_next;
  logic [18:0] pay_cnt_reg, pay_cnt_next;
  logic [18:0] rd_cnt_reg, rd_cnt_next;
  logic [7:0]  csum_reg, csum_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg, tx_valid_next;
  logic        tx_last_reg, tx_last_next;
  logic        rden_reg, rden_next;
  logic [10:0] rdaddr_reg, rdaddr_next;
  logic [1:0]  rd_pipe_reg, rd_pipe_next;
  logic [1:0]  wr_ptr_reg, wr_ptr_next;
  logic [1:0]  rd_ptr_reg, rd_ptr_next;
  logic [2:0]  fifo_cnt_reg, fifo_cnt_next;

  logic        load, pop, push, idle_like, start_pend, start_make;
  logic [7:0]  hdr_byte;
  logic [3:0]  occ;
  logic [15:0] make_pts;
  logic [7:0]  fifo_slots [4];

  function automatic logic [15:0] clamp_pts(input logic [15:0] p);
    return (p > MAX_PTS) ? MAX_PTS : p;
  endfunction

  assign push     = rd_pipe_reg[1];
  assign make_pts = clamp_pts(i_calib_points);

  // Data slots carry no reset; occupancy and pointers alone define FIFO contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      logic [7:0] slot_reg;
      always_ff @(posedge i_clk_50m) begin
        if (push && wr_ptr_reg == 2'(gi)) slot_reg <= i_ram_rddata;
      end
      assign fifo_slots[gi] = slot_reg;
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    seq_next         = seq_reg;
    bank_next        = bank_reg;
    points_next      = points_reg;
    len_next         = len_reg;
    pend_valid_next  = pend_valid_reg;
    pend_bank_next   = pend_bank_reg;
    pend_points_next = pend_points_reg;
    drop_next        = drop_reg;
    hdr_idx_next     = hdr_idx_reg;
    pay_cnt_next     = pay_cnt_reg;
    rd_cnt_next      = rd_cnt_reg;
    csum_next        = csum_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = tx_valid_reg;
    tx_last_next     = tx_last_reg;
    rdaddr_next      = rdaddr_reg;
    pop              = 1'b0;
    hdr_byte         = 8'h00;

    // The output register may take a new byte whenever it is empty or being accepted.
    load = !tx_valid_reg || i_tx_ready;
    if (load) begin
      tx_valid_next = 1'b0;
      tx_last_next  = 1'b0;
    end

    idle_like  = (state_reg == S_IDLE) || (state_reg == S_DONE);
    start_pend = idle_like && pend_valid_reg;
    start_make = idle_like && !pend_valid_reg && i_calib_make;

    case (state_reg)
      S_HDR: begin
        if (load) begin
          case (hdr_idx_reg)
            3'd0:    hdr_byte = SYNC_WORD[15:8];
            3'd1:    hdr_byte = SYNC_WORD[7:0];
            3'd2:    hdr_byte = FRAME_TYPE;
            3'd3:    hdr_byte = seq_reg;
            3'd4:    hdr_byte = points_reg[15:8];
            default: hdr_byte = points_reg[7:0];
          endcase
          tx_valid_next = 1'b1;
          tx_data_next  = hdr_byte;
          if (hdr_idx_reg >= 3'd2) csum_next = csum_reg ^ hdr_byte;
          hdr_idx_next = hdr_idx_reg + 3'd1;
          if (hdr_idx_reg == 3'd5) state_next = (len_reg == 19'd0) ? S_CSUM : S_PAY;
        end
      end
      S_PAY: begin
        if (load && fifo_cnt_reg != 3'd0) begin
          pop           = 1'b1;
          tx_valid_next = 1'b1;
          tx_data_next  = fifo_slots[rd_ptr_reg];
          csum_next     = csum_reg ^ fifo_slots[rd_ptr_reg];
          pay_cnt_next  = pay_cnt_reg + 19'd1;
          if (pay_cnt_reg == len_reg - 19'd1) state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        // tx_last_reg marks that the checksum already sits in the output register.
        if (!tx_last_reg) begin
          if (load) begin
            tx_valid_next = 1'b1;
            tx_last_next  = 1'b1;
            tx_data_next  = csum_reg;
          end
        end else if (i_tx_ready) begin
          seq_next   = seq_reg + 8'd1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: ;
    endcase

    if (start_pend || start_make) begin
      state_next   = S_HDR;
      bank_next    = start_pend ? pend_bank_reg : ~i_calib_pingpang;
      points_next  = start_pend ? pend_points_reg : make_pts;
      len_next     = {start_pend ? pend_points_reg : make_pts, 3'b000};
      hdr_idx_next = 3'd0;
      pay_cnt_next = 19'd0;
      rd_cnt_next  = 19'd0;
      csum_next    = 8'h00;
    end
    if (start_pend) pend_valid_next = 1'b0;

    // A make coinciding with the slot being consumed refills the slot instead of dropping.
    if (i_calib_make && !start_make) begin
      if (!pend_valid_reg || start_pend) begin
        pend_valid_next  = 1'b1;
        pend_bank_next   = ~i_calib_pingpang;
        pend_points_next = make_pts;
      end else if (drop_reg != 8'hFF) begin
        drop_next = drop_reg + 8'd1;
      end
    end

    // Credit counts the FIFO after this cycle's push/pop plus reads still in the pipe.
    occ = {1'b0, fifo_cnt_reg} + {3'b000, push} + {3'b000, rden_reg}
        + {3'b000, rd_pipe_reg[0]} - {3'b000, pop};
    rden_next = ((state_reg == S_HDR) || (state_reg == S_PAY))
              && (rd_cnt_reg < len_reg) && (occ < 4'd4);
    if (rden_next) begin
      rdaddr_next = {bank_reg, rd_cnt_reg[9:0]};
      rd_cnt_next = rd_cnt_reg + 19'd1;
    end
    rd_pipe_next  = {rd_pipe_reg[0], rden_reg};
    fifo_cnt_next = fifo_cnt_reg + {2'b00, push} - {2'b00, pop};
    wr_ptr_next   = wr_ptr_reg + {1'b0, push};
    rd_ptr_next   = rd_ptr_reg + {1'b0, pop};
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_reg       <= S_IDLE;
      seq_reg         <= 8'h00;
      bank_reg        <= 1'b0;
      points_reg      <= 16'h0000;
      len_reg         <= 19'd0;
      pend_valid_reg  <= 1'b0;
      pend_bank_reg   <= 1'b0;
      pend_points_reg <= 16'h0000;
      drop_reg        <= 8'h00;
      hdr_idx_reg     <= 3'd0;
      pay_cnt_reg     <= 19'd0;
      rd_cnt_reg      <= 19'd0;
      csum_reg        <= 8'h00;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      tx_last_reg     <= 1'b0;
      rden_reg        <= 1'b0;
      rdaddr_reg      <= 11'd0;
      rd_pipe_reg     <= 2'b00;
      wr_ptr_reg      <= 2'd0;
      rd_ptr_reg      <= 2'd0;
      fifo_cnt_reg    <= 3'd0;
    end else begin
      state_reg       <= state_next;
      seq_reg         <= seq_next;
      bank_reg        <= bank_next;
      points_reg      <= points_next;
      len_reg         <= len_next;
      pend_valid_reg  <= pend_valid_next;
      pend_bank_reg   <= pend_bank_next;
      pend_points_reg <= pend_points_next;
      drop_reg        <= drop_next;
      hdr_idx_reg     <= hdr_idx_next;
      pay_cnt_reg     <= pay_cnt_next;
      rd_cnt_reg      <= rd_cnt_next;
      csum_reg        <= csum_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      tx_last_reg     <= tx_last_next;
      rden_reg        <= rden_next;
      rdaddr_reg      <= rdaddr_next;
      rd_pipe_reg     <= rd_pipe_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      fifo_cnt_reg    <= fifo_cnt_next;
    end
  end

  assign o_ram_rdaddr = rdaddr_reg;
  assign o_ram_rden   = rden_reg;
  assign o_tx_data    = tx_data_reg;
  assign o_tx_valid   = tx_valid_reg;
  assign o_tx_last    = tx_last_reg;
  assign o_busy       = (state_reg != S_IDLE);
  assign o_drop_cnt   = drop_reg;

endmodule

// File: tb/tb_calib_frame_tx.sv
// Scoreboard bench for calib_frame_tx: stimulus pushes expected frame bytes, a monitor pops on handshake.
module tb_calib_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        make = 1'b0;
  logic        pingpang = 1'b0;
  logic [15:0] points = 16'd0;
  logic [10:0] rdaddr;
  logic        rden;
  logic [7:0]  rddata = 8'h00;
  logic [7:0]  txd;
  logic        txv;
  logic        txr = 1'b1;
  logic        txl;
  logic        busy;
  logic [7:0]  drop;

  always #5 clk = ~clk;

  calib_frame_tx u_dut (
    .i_clk_50m       (clk),
    .i_rst           (rst),
    .i_calib_make    (make),
    .i_calib_pingpang(pingpang),
    .i_calib_points  (points),
    .o_ram_rdaddr    (rdaddr),
    .o_ram_rden      (rden),
    .i_ram_rddata    (rddata),
    .o_tx_data       (txd),
    .o_tx_valid      (txv),
    .i_tx_ready      (txr),
    .o_tx_last       (txl),
    .o_busy          (busy),
    .o_drop_cnt      (drop)
  );

  // RAM model with two-cycle read latency.
  logic [7:0] mem [0:2047];
  logic [7:0] ram_p1 = 8'h00;
  always @(posedge clk) begin
    ram_p1 <= mem[rdaddr];
    rddata <= ram_p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] tb_seq = 8'h00;

  // Monitor state
  int   byte_idx = 0, frame_len = 0, frames = 0;
  int   start_cyc = 0, end_cyc = 0, last_gap = 0;
  int   issued = 0, pay_acc = 0;
  bit   in_frame = 0, prev_stall = 0, prev_rst = 1;
  logic [7:0] prev_d = 8'h00, last_seq = 8'h00, last_csum = 8'h00;
  logic       prev_l = 1'b0;

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rst) begin
        checks++;
        if (!(txv && txd == prev_d && txl == prev_l)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b", txv, txd, txl, prev_d, prev_l);
        end
      end
      if (in_frame && !prev_rst) begin
        checks++;
        if (!txv) begin
          errors++;
          $display("FAIL valid_gap: got valid=0 mid-frame at byte %0d want 1", byte_idx);
        end
      end
      if (rden) begin
        issued++;
        checks++;
        if (issued - pay_acc > 5) begin
          errors++;
          $display("FAIL read_credit: got %0d outstanding want <=5", issued - pay_acc);
        end
      end
      if (txv && txr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got d=%02h l=%0b want no byte", txd, txl);
        end else begin
          e = exp_q.pop_front();
          if ({txl, txd} !== e) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got d=%02h l=%0b want d=%02h l=%0b", byte_idx, txd, txl, e[7:0], e[8]);
          end
        end
        if (byte_idx == 0) begin
          start_cyc = cyc;
          last_gap  = cyc - end_cyc;
        end
        if (byte_idx == 3) last_seq = txd;
        if (byte_idx >= 6 && !txl) pay_acc++;
        byte_idx++;
        in_frame = 1;
        if (txl) begin
          frame_len = byte_idx;
          end_cyc   = cyc;
          last_csum = txd;
          in_frame  = 0;
          byte_idx  = 0;
          frames++;
        end
        $display("tx byte d=%02h last=%0b cyc=%0d", txd, txl, cyc);
      end
      prev_stall = txv && !txr;
      prev_d     = txd;
      prev_l     = txl;
      prev_rst   = rst;
      if (rst) begin
        exp_q.delete();
        in_frame = 0;
        byte_idx = 0;
        issued   = 0;
        pay_acc  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push_frame(input logic pp, input logic [15:0] pts_raw);
    logic [15:0] pts;
    logic [7:0]  x, b;
    logic [10:0] a;
    pts = (pts_raw > 16'd128) ? 16'd128 : pts_raw;
    exp_q.push_back({1'b0, 8'hCA});
    exp_q.push_back({1'b0, 8'h1B});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, tb_seq});
    exp_q.push_back({1'b0, pts[15:8]});
    exp_q.push_back({1'b0, pts[7:0]});
    x = 8'h5A ^ tb_seq ^ pts[15:8] ^ pts[7:0];
    for (int k = 0; k < int'(pts) * 8; k++) begin
      a = {~pp, 10'(k)};
      b = mem[a];
      x ^= b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b1, x});
    tb_seq++;
  endtask

  task automatic issue_make(input logic pp, input logic [15:0] pts);
    make = 1'b1;
    pingpang = pp;
    points = pts;
    tick();
    make = 1'b0;
    $display("make pingpang=%0b points=%0d cyc=%0d", pp, pts, cyc);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      txr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    txr = 1'b1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: got timeout after %0d cycles want idle, %0d bytes left", n, exp_q.size());
    end
    tick();
  endtask

  logic [7:0] basic_vec [0:22];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] ia;
      ia = 11'(i);
      mem[i] = ia[10] ? (ia[7:0] ^ {6'b0, ia[9:8]}) : (8'hFF - ia[7:0]) ^ {ia[9:8], 6'b0};
    end
    basic_vec = '{8'hCA, 8'h1B, 8'h5A, 8'h00, 8'h00, 8'h02,
                  8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h58};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(txv), 0);
    check("rst_last", 32'(txl), 0);
    check("rst_data", 32'(txd), 0);
    check("rst_rden", 32'(rden), 0);
    check("rst_rdaddr", 32'(rdaddr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Basic frame: hand-written vector, latency and throughput
    for (int i = 0; i < 23; i++) exp_q.push_back({(i == 22), basic_vec[i]});
    tb_seq = 8'h01;
    make = 1'b1; pingpang = 1'b0; points = 16'd2;
    tick();
    make = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", 32'(txv), 0);
    @(negedge clk);
    check("lat_t2_valid", 32'(txv), 1);
    check("lat_t2_data", 32'(txd), 32'hCA);
    wait_idle(200, 0);
    check("basic_len", 32'(frame_len), 23);
    check("basic_span", 32'(end_cyc - start_cyc), 22);

    // Backpressure
    push_frame(1'b0, 16'd2);
    issue_make(1'b0, 16'd2);
    wait_idle(500, 1);
    check("bp_len", 32'(frame_len), 23);
    check("bp_seq", 32'(last_seq), 32'h01);

    // Zero points
    push_frame(1'b0, 16'd0);
    issue_make(1'b0, 16'd0);
    wait_idle(100, 0);
    check("zero_len", 32'(frame_len), 7);
    check("zero_csum", 32'(last_csum), 32'h58);

    // Clamp
    push_frame(1'b1, 16'd300);
    issue_make(1'b1, 16'd300);
    wait_idle(3000, 0);
    check("clamp_len", 32'(frame_len), 1031);

    // Overlap and single drop
    push_frame(1'b1, 16'd2);
    issue_make(1'b1, 16'd2);
    repeat (8) tick();
    push_frame(1'b0, 16'd1);
    issue_make(1'b0, 16'd1);
    repeat (2) tick();
    issue_make(1'b1, 16'd3);
    wait_idle(300, 0);
    check("overlap_drop", 32'(drop), 1);
    check("overlap_gap", 32'(last_gap), 3);
    check("overlap_seq", 32'(last_seq), 32'h05);

    // Saturating drops during a long frame
    push_frame(1'b0, 16'd128);
    issue_make(1'b0, 16'd128);
    repeat (5) tick();
    push_frame(1'b1, 16'd1);
    issue_make(1'b1, 16'd1);
    make = 1'b1; points = 16'd2;
    repeat (300) tick();
    make = 1'b0;
    wait_idle(3000, 0);
    check("drop_sat", 32'(drop), 255);

    // Reset mid-payload
    push_frame(1'b0, 16'd16);
    issue_make(1'b0, 16'd16);
    begin
      int n = 0;
      while (byte_idx < 10 && n < 200) begin tick(); n++; end
      check("rst_reach_byte10", 32'(n < 200), 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tb_seq = 8'h00;
    @(negedge clk);
    check("midrst_valid", 32'(txv), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_drop", 32'(drop), 0);
    check("midrst_rden", 32'(rden), 0);
    repeat (3) tick();
    push_frame(1'b0, 16'd2);
    issue_make(1'b0, 16'd2);
    wait_idle(200, 0);
    check("postrst_seq", 32'(last_seq), 32'h00);
    check("postrst_csum", 32'(last_csum), 32'h58);

    // Sequence wrap
    begin
      int f0;
      f0 = frames;
      for (int i = 0; i < 257; i++) begin
        push_frame(1'b0, 16'd0);
        issue_make(1'b0, 16'd0);
        wait_idle(100, 0);
      end
      check("wrap_frames", 32'(frames - f0), 257);
      check("wrap_seq", 32'(last_seq), 32'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
